// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with single-outstanding-miss block refill.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT ports.
module instr_cache #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned INDEX_BITS  = 3,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [31:0]                 PC,
    output logic [31:0]                 INSTRUCTION,
    output logic                        BUSYWAIT,
    output logic                        MEM_READ,
    output logic [ADDR_BITS-5:0]        MEM_ADDRESS,
    input  logic [BLOCK_WORDS*32-1:0]   MEM_READDATA,
    input  logic                        MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                 HIT_COUNT,
    output logic [15:0]                 MISS_COUNT
`endif
);

    localparam int unsigned NumBlocks = 1 << INDEX_BITS;
    localparam int unsigned BlkBits   = ADDR_BITS - 4;
    localparam int unsigned TagBits   = ADDR_BITS - 4 - INDEX_BITS;
    localparam int unsigned LineBits  = BLOCK_WORDS * 32;

    typedef enum logic [1:0] {StIdle, StMemRead, StUpdate} state_e;

    state_e                state_q, state_d;
    logic [NumBlocks-1:0]  valid_q, valid_d;
    logic [TagBits-1:0]    tag_q  [NumBlocks];
    logic [TagBits-1:0]    tag_d  [NumBlocks];
    logic [LineBits-1:0]   data_q [NumBlocks];
    logic [LineBits-1:0]   data_d [NumBlocks];
    logic [BlkBits-1:0]    addr_q, addr_d;
    logic [LineBits-1:0]   line_q, line_d;
    logic [31:0]           instr_q, instr_d;

    logic [1:0]            pc_offset;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TagBits-1:0]    pc_tag;
    logic                  hit;
    logic [31:0]           hit_word;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TagBits-1:0]    fill_tag;
    logic                  unused_pc;

    assign pc_offset  = PC[3:2];
    assign pc_index   = PC[3+INDEX_BITS:4];
    assign pc_tag     = PC[ADDR_BITS-1:4+INDEX_BITS];
    assign unused_pc  = ^{PC[31:ADDR_BITS], PC[1:0]};

    assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign hit_word   = data_q[pc_index][{pc_offset, 5'b0} +: 32];
    assign fill_index = addr_q[INDEX_BITS-1:0];
    assign fill_tag   = addr_q[BlkBits-1:INDEX_BITS];

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        addr_d      = addr_q;
        line_d      = line_q;
        instr_d     = instr_q;
        INSTRUCTION = instr_q;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;

        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    INSTRUCTION = hit_word;
                    instr_d     = hit_word;
                end else begin
                    BUSYWAIT = 1'b1;
                    addr_d   = {pc_tag, pc_index};
                    state_d  = StMemRead;
                end
            end
            StMemRead: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = addr_q;
                if (!MEM_BUSYWAIT) begin
                    line_d  = MEM_READDATA;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                BUSYWAIT            = 1'b1;
                valid_d[fill_index] = 1'b1;
                tag_d[fill_index]   = fill_tag;
                data_d[fill_index]  = line_q;
                state_d             = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The CPU must never stall while the cache is being reset.
        if (!RESET) begin
            BUSYWAIT = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StIdle;
            valid_q <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            instr_q <= instr_d;
        end
    end

    // Payload arrays need no reset; gating on RESET keeps an abandoned fill from writing.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == StIdle) begin
            if (hit && hit_count_q != 16'hFFFF) begin
                hit_count_d = hit_count_q + 16'd1;
            end
            if (!hit && miss_count_q != 16'hFFFF) begin
                miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios then random fetches against a
// behavioural model of a direct-mapped cache over a 1 KiB instruction memory.
module tb_instr_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [31:0]  PC = '0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;
`endif

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Instruction memory: 256 words, answers after mem_lat busy cycles.
    logic [31:0] mem_w [256];
    int          mem_lat = 0;
    int          mem_cnt = 0;

    always @(posedge CLK) begin
        if (MEM_READ && mem_cnt < mem_lat) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end

    assign MEM_BUSYWAIT = !(MEM_READ && mem_cnt >= mem_lat);

    always_comb begin
        MEM_READDATA = '0;
        for (int w = 0; w < 4; w++) begin
            MEM_READDATA[w*32 +: 32] = mem_w[int'(MEM_ADDRESS) * 4 + w];
        end
    end

    // Reference model
    bit ref_valid [8];
    int ref_tag   [8];
    int ref_hits;
    int ref_miss;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        int idx = int'((pc >> 4) % 8);
        int tg  = int'((pc >> 7) % 8);
        return ref_valid[idx] && ref_tag[idx] == tg;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        ref_hits = 0;
        ref_miss = 0;
    endtask

    task automatic chk_stats(input string tag);
`ifdef ICACHE_STATS_EN
        chk({tag, "_hits"}, 32'(HIT_COUNT), 32'(ref_hits));
        chk({tag, "_misses"}, 32'(MISS_COUNT), 32'(ref_miss));
`else
        chk({tag, "_memrd"}, 32'(MEM_READ), 32'(0));
`endif
    endtask

    // Entered and left at a negedge.
    task automatic do_reset();
        RESET = 1'b0;
        PC    = '0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_busywait", 32'(BUSYWAIT), 32'(0));
        chk("rst_memread", 32'(MEM_READ), 32'(0));
        chk("rst_instr", INSTRUCTION, 32'(0));
        model_clear();
        chk_stats("rst");
        RESET = 1'b1;
    endtask

    // Entered and left at a negedge; each fetch ends with exactly one hit edge.
    task automatic fetch(input logic [31:0] pc);
        bit exp_hit;
        int idx;
        int cycles;
        int blk;
        exp_hit = model_hit(pc);
        idx     = int'((pc >> 4) % 8);
        blk     = int'((pc >> 4) % 64);
        PC      = pc;
        #1;
        chk("busywait_at_fetch", 32'(BUSYWAIT), 32'(!exp_hit));
        if (!exp_hit) begin
            ref_miss = (ref_miss < 65535) ? ref_miss + 1 : ref_miss;
            cycles   = 1;
            @(posedge CLK);
            #1;
            chk("miss_memread", 32'(MEM_READ), 32'(1));
            chk("miss_memaddr", 32'(MEM_ADDRESS), 32'(blk));
            while (BUSYWAIT && cycles < 200) begin
                @(posedge CLK);
                #1;
                cycles++;
                if (MEM_READ) chk("memaddr_stable", 32'(MEM_ADDRESS), 32'(blk));
            end
            chk("stall_cycles", 32'(cycles), 32'(mem_lat + 3));
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = int'((pc >> 7) % 8);
        end
        chk("instr", INSTRUCTION, mem_w[int'((pc >> 2) % 256)]);
        chk("idle_memread", 32'(MEM_READ), 32'(0));
        chk("idle_memaddr", 32'(MEM_ADDRESS), 32'(0));
        @(posedge CLK);
        ref_hits = (ref_hits < 65535) ? ref_hits + 1 : ref_hits;
        @(negedge CLK);
    endtask

    // Starts a miss on pc and resets while the memory read is pending.
    task automatic reset_midfill(input logic [31:0] pc);
        PC = pc;
        @(posedge CLK);
        @(negedge CLK);
        chk("midfill_memread", 32'(MEM_READ), 32'(1));
        RESET = 1'b0;
        #1;
        chk("busywait_in_reset", 32'(BUSYWAIT), 32'(0));
        @(posedge CLK);
        #1;
        chk("midfill_abort", 32'(MEM_READ), 32'(0));
        @(negedge CLK);
        RESET = 1'b1;
        model_clear();
        chk_stats("midfill");
    endtask

    initial begin
        logic [31:0] pc;
        for (int i = 0; i < 256; i++) mem_w[i] = $urandom;
        mem_w[0] = 32'hAAAA_0001;
        mem_w[1] = 32'hBBBB_0002;
        mem_w[2] = 32'hCCCC_0003;
        mem_w[3] = 32'hDDDD_0004;
        model_clear();

        // Reset, cold miss on 0x000 with 5 cycles of MEM_READ, then hits across the line.
        do_reset();
        mem_lat = 4;
        fetch(32'h000);
        fetch(32'h004);
        fetch(32'h008);
        fetch(32'h00C);
        chk_stats("cold_fill");

        // Conflict on index 0, then aliasing above the 1 KiB space.
        mem_lat = 1;
        fetch(32'h080);
        fetch(32'h000);
        fetch(32'h400);
        fetch(32'hFFFF_F402);

        // Reset mid-fill: the same PC must miss again afterwards.
        mem_lat = 6;
        reset_midfill(32'h100);
        fetch(32'h100);
        fetch(32'h000);

        // Random traffic, mostly inside a 16-block region so hits recur.
        for (int n = 0; n < 150; n++) begin
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[9:0] = 10'($urandom_range(0, 255));
            mem_lat = $urandom_range(0, 6);
            if ($urandom_range(0, 19) == 0 && !model_hit(pc)) reset_midfill(pc);
            fetch(pc);
        end
        chk_stats("random_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
